// File: rtl/rsa_msg_loader.sv
// -----------------------------------------------------------------------------
// rsa_msg_loader
// Upstream feeder for the RSA encryptor. Packs a byte stream (MSB byte first)
// into one WIDTH-bit block, range-checks it against modulus n, hands an
// accepted block to the encryptor with a one-cycle start pulse, then waits for
// the encryptor's done level before taking the next block.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous reset, active low
//   in_data    in   8      input byte
//   in_valid   in   1      in_data valid
//   in_last    in   1      in_data is the final byte of a short block
//   in_ready   out  1      a byte can be accepted this cycle (state decode)
//   n          in   WIDTH  RSA modulus, stable from CHECK through WAIT
//   message    out  WIDTH  last accepted block, held until the next acceptance
//   enc_start  out  1      one-cycle registered start pulse
//   enc_done   in   1      encryptor done level
//   busy       out  1      high in CHECK, START and WAIT (state decode)
//   err_range  out  1      one-cycle pulse: block >= n, or n == 0
//   blk_count  out  CNT_W  blocks completed by the encryptor, wraps silently
// -----------------------------------------------------------------------------
module rsa_msg_loader #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] message,
    output logic             enc_start,
    input  logic             enc_done,
    output logic             busy,
    output logic             err_range,
    output logic [CNT_W-1:0] blk_count
);

    localparam int BYTES = WIDTH / 8;
    localparam int BC_W  = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_CHECK = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BC_W-1:0]  r_byte_cnt;
    logic [WIDTH-1:0] r_message;
    logic             r_enc_start;
    logic             r_err_range;
    logic [CNT_W-1:0] r_blk_count;
    logic             r_wait_first;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_in_range;

    // A byte is consumed only in FILL; in_ready is exactly that state decode.
    assign w_accept    = in_valid && (r_state == S_FILL);
    // Block closes on the BYTES-th byte or on an explicit in_last.
    assign w_last_beat = (r_byte_cnt == BC_W'(BYTES - 1)) || in_last;
    // n == 0 can never hold a valid message, so it always rejects.
    assign w_in_range  = (n != {WIDTH{1'b0}}) && (r_shift < n);

    // Loader state machine with all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_FILL;
            r_shift      <= {WIDTH{1'b0}};
            r_byte_cnt   <= {BC_W{1'b0}};
            r_message    <= {WIDTH{1'b0}};
            r_enc_start  <= 1'b0;
            r_err_range  <= 1'b0;
            r_blk_count  <= {CNT_W{1'b0}};
            r_wait_first <= 1'b0;
        end else begin
            // Pulses default low; the states below raise them for one cycle.
            r_enc_start <= 1'b0;
            r_err_range <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_shift    <= {r_shift[WIDTH-9:0], in_data};
                        r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        if (w_last_beat) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_in_range) begin
                        r_message   <= r_shift;
                        // Start is raised here so it is high for the whole START cycle.
                        r_enc_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_err_range <= 1'b1;
                        r_shift     <= {WIDTH{1'b0}};
                        r_byte_cnt  <= {BC_W{1'b0}};
                        r_state     <= S_FILL;
                    end
                end
                S_START: begin
                    r_shift      <= {WIDTH{1'b0}};
                    r_byte_cnt   <= {BC_W{1'b0}};
                    r_wait_first <= 1'b1;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // The first WAIT cycle may still see the previous block's done level.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (enc_done) begin
                        r_blk_count <= r_blk_count + CNT_W'(1);
                        r_state     <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_FILL);
    assign busy      = (r_state != S_FILL);
    assign message   = r_message;
    assign enc_start = r_enc_start;
    assign err_range = r_err_range;
    assign blk_count = r_blk_count;

endmodule

// File: tb/tb_rsa_msg_loader.sv
module tb_rsa_msg_loader;

    localparam int WIDTH = 128;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] message;
    logic             enc_start;
    logic             enc_done;
    logic             busy;
    logic             err_range;
    logic [CNT_W-1:0] blk_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: last accepted block and number of completed blocks.
    logic [WIDTH-1:0] m_message;
    int               m_count;

    rsa_msg_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .n         (n),
        .message   (message),
        .enc_start (enc_start),
        .enc_done  (enc_done),
        .busy      (busy),
        .err_range (err_range),
        .blk_count (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Block value as a number: bytes arrive most significant first.
    function automatic logic [WIDTH-1:0] pack(input logic [7:0] q[$]);
        logic [WIDTH-1:0] v;
        v = '0;
        foreach (q[i]) v = v * 128'd256 + 128'(q[i]);
        return v;
    endfunction

    function automatic int exp_ready_cyc(input bit acc, input int d, input bit hold);
        if (!acc) return 1;
        if (hold) return 4;
        return 3 + ((d < 1) ? 1 : d);
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic last, output bit ok);
        int k;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 100) begin
            step();
            k++;
        end
        ok = in_ready;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_block(input logic [7:0] q[$], input bit with_last, input bit gaps, output bit ok);
        bit ok_i;
        ok = 1'b1;
        foreach (q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            push_byte(q[i], with_last && (i == q.size() - 1), ok_i);
            ok = ok && ok_i;
        end
    endtask

    // Walks from the cycle after the last byte until in_ready returns, driving
    // ignored garbage on the byte port and enc_done d cycles after the pulse.
    task automatic run_tail(input int d, input bit hold, output logic ready0,
                            output int start_cnt, output int start_cyc,
                            output int err_cnt, output int err_cyc, output int ready_cyc);
        start_cnt = 0; start_cyc = -1; err_cnt = 0; err_cyc = -1; ready_cyc = -1;
        ready0 = in_ready;
        for (int c = 0; c < 200; c++) begin
            if (enc_start) begin start_cnt++; if (start_cyc < 0) start_cyc = c; end
            if (err_range) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
            if (c > 0 && in_ready) begin ready_cyc = c; break; end
            enc_done = hold || (start_cyc >= 0 && c >= start_cyc + 1 + d);
            in_valid = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            step();
        end
        enc_done = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic play(input logic [7:0] q[$], input bit with_last, input logic [WIDTH-1:0] n_val,
                        input int d, input bit hold, input bit gaps,
                        output bit ok, output logic ready0, output int start_cnt, output int start_cyc,
                        output int err_cnt, output int err_cyc, output int ready_cyc);
        n = n_val;
        send_block(q, with_last, gaps, ok);
        run_tail(d, hold, ready0, start_cnt, start_cyc, err_cnt, err_cyc, ready_cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; n = '0; enc_done = 1'b0;
        m_message = '0; m_count = 0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (message !== '0) begin tests_failed++; $display("FAIL reset_message: got %h want 0", message); end
        tests_run++; if (enc_start !== 1'b0 || err_range !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: start %b err %b want 0 0", enc_start, err_range); end
        tests_run++; if (blk_count !== '0) begin tests_failed++; $display("FAIL reset_blk_count: got %0d want 0", blk_count); end
    endtask

    task automatic test_full_block();
        logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        play(q, 1'b0, {WIDTH{1'b1}}, 2, 1'b0, 1'b0, ok, r0, sc, scy, ec, ecy, rc);
        m_message = 128'h000102030405060708090A0B0C0D0E0F;
        m_count = (m_count + 1) % 16;
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL full_bytes_taken: in_ready never high"); end
        tests_run++; if (r0 !== 1'b0) begin tests_failed++; $display("FAIL full_ready_after_last: got %b want 0", r0); end
        tests_run++; if (sc != 1 || scy != 1) begin tests_failed++; $display("FAIL full_start: count %0d at cycle %0d want 1 at 1", sc, scy); end
        tests_run++; if (ec != 0) begin tests_failed++; $display("FAIL full_err: got %0d pulses want 0", ec); end
        tests_run++; if (rc != 5) begin tests_failed++; $display("FAIL full_ready_return: got cycle %0d want 5", rc); end
        tests_run++; if (message !== m_message) begin tests_failed++; $display("FAIL full_message: got %h want %h", message, m_message); end
        tests_run++; if (blk_count !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL full_blk_count: got %0d want %0d", blk_count, m_count); end
    endtask

    task automatic test_short_block();
        logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
        q = '{8'hAB, 8'hCD};
        play(q, 1'b1, 128'd1 << 100, 0, 1'b0, 1'b1, ok, r0, sc, scy, ec, ecy, rc);
        m_message = 128'hABCD;
        m_count = (m_count + 1) % 16;
        tests_run++; if (sc != 1 || scy != 1) begin tests_failed++; $display("FAIL short_start: count %0d at cycle %0d want 1 at 1", sc, scy); end
        tests_run++; if (rc != 4) begin tests_failed++; $display("FAIL short_ready_return: got cycle %0d want 4", rc); end
        tests_run++; if (message !== m_message) begin tests_failed++; $display("FAIL short_message: got %h want %h", message, m_message); end
        tests_run++; if (blk_count !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL short_blk_count: got %0d want %0d", blk_count, m_count); end
    endtask

    task automatic test_range_reject();
        logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
        for (int i = 0; i < 16; i++) q.push_back(8'hFF);
        play(q, 1'b0, 128'd1 << 127, 0, 1'b0, 1'b0, ok, r0, sc, scy, ec, ecy, rc);
        tests_run++; if (ec != 1 || ecy != 1) begin tests_failed++; $display("FAIL reject_err: count %0d at cycle %0d want 1 at 1", ec, ecy); end
        tests_run++; if (sc != 0) begin tests_failed++; $display("FAIL reject_start: got %0d pulses want 0", sc); end
        tests_run++; if (rc != 1) begin tests_failed++; $display("FAIL reject_ready_return: got cycle %0d want 1", rc); end
        tests_run++; if (message !== m_message) begin tests_failed++; $display("FAIL reject_message_held: got %h want %h", message, m_message); end
        step();
        tests_run++; if (err_range !== 1'b0) begin tests_failed++; $display("FAIL reject_err_one_cycle: got %b want 0", err_range); end
    endtask

    task automatic test_n_zero();
        logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
        q = '{8'h00};
        play(q, 1'b1, '0, 0, 1'b0, 1'b0, ok, r0, sc, scy, ec, ecy, rc);
        tests_run++; if (ec != 1 || sc != 0) begin tests_failed++; $display("FAIL nzero: err %0d start %0d want 1 0", ec, sc); end
        tests_run++; if (blk_count !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL nzero_blk_count: got %0d want %0d", blk_count, m_count); end
    endtask

    task automatic test_stale_done();
        logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        play(q, 1'b0, {WIDTH{1'b1}}, 0, 1'b1, 1'b0, ok, r0, sc, scy, ec, ecy, rc);
        m_message = pack(q);
        m_count = (m_count + 1) % 16;
        tests_run++; if (rc != 4) begin tests_failed++; $display("FAIL stale_ready_return: got cycle %0d want 4", rc); end
        tests_run++; if (blk_count !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL stale_blk_count: got %0d want %0d", blk_count, m_count); end
        tests_run++; if (message !== m_message) begin tests_failed++; $display("FAIL stale_message: got %h want %h", message, m_message); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
            int len, kind, d; bit wl, hold, acc;
            logic [WIDTH-1:0] blk, nv;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            wl = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            blk = pack(q);
            kind = $urandom_range(0, 4);
            case (kind)
                0: nv = '0;
                1: nv = {WIDTH{1'b1}};
                2: nv = {$urandom, $urandom, $urandom, $urandom};
                3: nv = blk;
                default: nv = blk + 128'd1;
            endcase
            d = $urandom_range(0, 3);
            hold = ($urandom_range(0, 3) == 0);
            acc = (nv != 0) && (blk < nv);
            play(q, wl, nv, d, hold, 1'b1, ok, r0, sc, scy, ec, ecy, rc);
            if (acc) begin m_message = blk; m_count = (m_count + 1) % 16; end
            tests_run++; if (!ok || r0 !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d_feed: ok %b ready_after_last %b", it, ok, r0); end
            tests_run++; if (sc != int'(acc) || ec != int'(!acc)) begin tests_failed++; $display("FAIL rnd%0d_decision: start %0d err %0d want accept=%0d", it, sc, ec, acc); end
            tests_run++; if (rc != exp_ready_cyc(acc, d, hold)) begin tests_failed++; $display("FAIL rnd%0d_ready_return: got %0d want %0d", it, rc, exp_ready_cyc(acc, d, hold)); end
            tests_run++; if (message !== m_message) begin tests_failed++; $display("FAIL rnd%0d_message: got %h want %h", it, message, m_message); end
            tests_run++; if (blk_count !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL rnd%0d_blk_count: got %0d want %0d", it, blk_count, m_count); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$]; bit ok; logic r0; int sc, scy, ec, ecy, rc;
        n = {WIDTH{1'b1}};
        for (int i = 0; i < 7; i++) begin
            push_byte(8'hA0 + 8'(i), 1'b0, ok);
        end
        reset_n = 1'b0;
        #2;
        tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_state: ready %b busy %b want 1 0", in_ready, busy); end
        tests_run++; if (message !== '0 || blk_count !== '0) begin tests_failed++; $display("FAIL rstmid_outputs: msg %h cnt %0d want 0 0", message, blk_count); end
        m_message = '0; m_count = 0;
        step();
        reset_n = 1'b1;
        step();
        // Fifteen bytes must not close the block if the count restarted at zero.
        for (int i = 0; i < 15; i++) q.push_back(8'($urandom));
        send_block(q, 1'b0, 1'b0, ok);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_byte_cnt: ready %b after 15 bytes want 1", in_ready); end
        q.push_back(8'($urandom));
        push_byte(q[15], 1'b0, ok);
        run_tail(1, 1'b0, r0, sc, scy, ec, ecy, rc);
        m_message = pack(q); m_count = 1;
        tests_run++; if (message !== m_message) begin tests_failed++; $display("FAIL rstmid_clean_message: got %h want %h", message, m_message); end
        tests_run++; if (blk_count !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL rstmid_blk_count: got %0d want %0d", blk_count, m_count); end
        // Second reset while waiting on the encryptor.
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        send_block(q, 1'b0, 1'b0, ok);
        step(); step();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rstwait_busy_before: got %b want 1", busy); end
        reset_n = 1'b0;
        #2;
        tests_run++; if (busy !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstwait_state: busy %b ready %b want 0 1", busy, in_ready); end
        tests_run++; if (message !== '0 || blk_count !== '0 || enc_start !== 1'b0) begin tests_failed++; $display("FAIL rstwait_outputs: msg %h cnt %0d start %b want 0 0 0", message, blk_count, enc_start); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_range_reject();
        test_n_zero();
        test_stale_done();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
